// File: rtl/mul_seq_unit.sv
// Iterative 32x32->64 shift-and-add multiplier for the RV32M EX stage.
// One ripple adder is time-shared across WIDTH iterations.

// WIDTH-bit ripple-carry adder used once per multiplier iteration.
module bitadder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] Add1,
    input  logic [WIDTH-1:0] Add2,
    input  logic             Carry_In,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry_Out
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = Carry_In;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign Sum[gi]     = Add1[gi] ^ Add2[gi] ^ w_c[gi];
            assign w_c[gi + 1] = (Add1[gi] & Add2[gi])
                               | (w_c[gi] & (Add1[gi] ^ Add2[gi]));
        end
    endgenerate

    assign Carry_Out = w_c[WIDTH];

endmodule

module mul_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Start,
    input  logic               Is_Signed,
    input  logic [WIDTH-1:0]   Mcand,
    input  logic [WIDTH-1:0]   Mplier,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CW-1:0]      r_count;
    logic               r_neg;
    logic               r_done;
    logic [2*WIDTH-1:0] r_product;

    logic               w_load;
    logic               w_step;
    logic               w_fix;

    logic [WIDTH-1:0]   w_mcand_abs;
    logic [WIDTH-1:0]   w_mplier_abs;
    logic               w_neg;

    logic [WIDTH-1:0]   w_add2;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [2*WIDTH-1:0] w_acc;

    // Operand magnitudes; the most negative value maps to itself,
    // which is the correct unsigned magnitude.
    assign w_mcand_abs  = (Is_Signed && Mcand[WIDTH-1])  ? -Mcand  : Mcand;
    assign w_mplier_abs = (Is_Signed && Mplier[WIDTH-1]) ? -Mplier : Mplier;

    // Result sign; a zero operand always yields a non-negative product.
    assign w_neg = Is_Signed
                 & (Mcand[WIDTH-1] ^ Mplier[WIDTH-1])
                 & (|Mcand)
                 & (|Mplier);

    assign w_add2 = r_lo[0] ? r_a : '0;
    assign w_acc  = {r_hi, r_lo};

    bitadder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .Add1      (r_hi),
        .Add2      (w_add2),
        .Carry_In  (1'b0),
        .Sum       (w_sum),
        .Carry_Out (w_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (Start) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_count == LAST) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_fix        = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand load and one shift-add iteration per RUN cycle; the adder
    // carry becomes the new top bit of Hi.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_count <= '0;
            r_neg   <= 1'b0;
        end else if (w_load) begin
            r_a     <= w_mcand_abs;
            r_hi    <= '0;
            r_lo    <= w_mplier_abs;
            r_count <= '0;
            r_neg   <= w_neg;
        end else if (w_step) begin
            r_hi    <= {w_cout, w_sum[WIDTH-1:1]};
            r_lo    <= {w_sum[0], r_lo[WIDTH-1:1]};
            r_count <= r_count + 1'b1;
        end
    end

    // Sign fix-up into the visible product and the one-cycle Done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_fix) begin
                r_product <= r_neg ? -w_acc : w_acc;
            end
        end
    end

    assign Busy    = (r_state != IDLE);
    assign Done    = r_done;
    assign Product = r_product;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Self-checking bench for mul_seq_unit: directed corner cases,
// overlap/reset scenarios, and random operands vs. an arithmetic model.
module tb_mul_seq_unit;

    logic        clk;
    logic        rst;
    logic        Start;
    logic        Is_Signed;
    logic [31:0] Mcand;
    logic [31:0] Mplier;
    logic        Busy;
    logic        Done;
    logic [63:0] Product;

    int n_pass;
    int n_total;

    mul_seq_unit dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .Is_Signed (Is_Signed),
        .Mcand     (Mcand),
        .Mplier    (Mplier),
        .Busy      (Busy),
        .Done      (Done),
        .Product   (Product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        s
    );
        longint sa;
        longint sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic s);
        Start     = 1'b1;
        Mcand     = a;
        Mplier    = b;
        Is_Signed = s;
        tick();
        Start  = 1'b0;
        Mcand  = $urandom;
        Mplier = $urandom;
    endtask

    // Cycles counted from the accepting edge until Done is seen.
    task automatic wait_done(input int already, output int cyc);
        cyc = already;
        while (Done !== 1'b1 && cyc < 80) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic s);
        int cyc;
        launch(a, b, s);
        chk({tag, "_busy"}, 64'(Busy), 64'd1);
        wait_done(0, cyc);
        chk({tag, "_lat"}, 64'(cyc), 64'd33);
        chk({tag, "_prod"}, Product, ref_mul(a, b, s));
        chk({tag, "_busy_done"}, 64'(Busy), 64'd0);
        tick();
        chk({tag, "_done_pulse"}, 64'(Done), 64'd0);
    endtask

    initial begin
        int cyc;
        int dones;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        Start     = 1'b0;
        Is_Signed = 1'b0;
        Mcand     = '0;
        Mplier    = '0;
        tick();
        tick();
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_prod", Product, 64'd0);
        rst = 1'b0;
        tick();

        run_op("u3x5", 32'd3, 32'd5, 1'b0);
        chk("u3x5_lit", Product, 64'h0000_0000_0000_000F);
        run_op("uffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("uffxff_lit", Product, 64'hFFFF_FFFE_0000_0001);
        run_op("sm2x3", 32'hFFFF_FFFE, 32'd3, 1'b1);
        chk("sm2x3_lit", Product, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("sm1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("sm1xm1_lit", Product, 64'h1);
        run_op("smin2", 32'h8000_0000, 32'h8000_0000, 1'b1);
        chk("smin2_lit", Product, 64'h4000_0000_0000_0000);
        run_op("szero", 32'd0, 32'hFFFF_FFFB, 1'b1);
        run_op("uzero", 32'hDEAD_BEEF, 32'd0, 1'b0);

        // Start during RUN is ignored; Start in the Done cycle is taken.
        launch(32'd1234, 32'd5678, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        Start     = 1'b1;
        Mcand     = 32'h7777_7777;
        Mplier    = 32'h3333_3333;
        Is_Signed = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(11, cyc);
        chk("ovl_lat", 64'(cyc), 64'd33);
        chk("ovl_prod", Product, ref_mul(32'd1234, 32'd5678, 1'b0));
        Start     = 1'b1;
        Mcand     = 32'hFFFF_FF00;
        Mplier    = 32'd77;
        Is_Signed = 1'b1;
        tick();
        Start = 1'b0;
        chk("b2b_busy", 64'(Busy), 64'd1);
        chk("b2b_done_once", 64'(Done), 64'd0);
        chk("b2b_hold", Product, ref_mul(32'd1234, 32'd5678, 1'b0));
        wait_done(0, cyc);
        chk("b2b_lat", 64'(cyc), 64'd33);
        chk("b2b_prod", Product, ref_mul(32'hFFFF_FF00, 32'd77, 1'b1));
        tick();

        // Reset in the middle of RUN aborts with no Done.
        launch(32'd99, 32'd101, 1'b0);
        for (int i = 0; i < 19; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", 64'(Busy), 64'd0);
        chk("mrst_done", 64'(Done), 64'd0);
        chk("mrst_prod", Product, 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done === 1'b1) dones++;
        end
        chk("mrst_nodone", 64'(dones), 64'd0);
        run_op("post_rst", 32'd99, 32'd101, 1'b0);

        for (int k = 0; k < 8; k++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (k == 0) ra = 32'h8000_0000;
            if (k == 1) rb = 32'h7FFF_FFFF;
            run_op($sformatf("rnd%0d", k), ra, rb, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
